pin_entry_assembler: RTL and testbench

Sits between the keypad decoder and the PIN-check FSM, running on the slow clock produced by divfreq. It accepts one-cycle key events and assembles the last four digits into a rolling buffer. It drives four display nibbles into the BCDto7SEGMENT decoders and, on ENTER, emits a completed pinPac_t. It also handles backspace, an inactivity timeout and an enable gate.

---
 rtl/pin_pkg.sv | 28 ++
 rtl/pin_inactivity_timer.sv | 40 ++++
 rtl/pin_entry_assembler.sv | 132 +++++++++++++
 tb/tb_pin_entry_assembler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pin_pkg.sv
// Shared types and key/display constants for the PIN entry path between the
// keypad decoder and the PIN-check FSM.
package pin_pkg;

  localparam logic [3:0] KEY_BKSP        = 4'hA;
  localparam logic [3:0] KEY_ENTER       = 4'hC;
  localparam logic [3:0] EMPTY_DIGIT     = 4'hB;
  localparam logic [3:0] PIN_RESET_DIGIT = 4'hF;

  typedef struct packed {
    logic       status;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d4;
  } pinPac_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    SUBMIT = 2'd2
  } pinState_e;

  function automatic logic isDigit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_inactivity_timer.sv
// Inactivity timer: counts while run is high and flags expiry for one cycle
// when TIMEOUT_TICKS-1 is reached without a clear.
module pin_inactivity_timer
  import pin_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = run && !clear && (count_q == LAST_TICK);

  // Counter rests at zero whenever it is not running, so IDLE never accumulates.
  always_comb begin
    count_d = count_q;
    if (clear || !run || expire) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pin_entry_assembler.sv
// Assembles keypad events into a rolling four-digit buffer, drives the display
// nibbles and emits a completed PIN packet on ENTER.
module pin_entry_assembler
  import pin_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 5000,
  parameter int PIN_LEN       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output pinPac_t    pin_out,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d4,
  output logic [2:0] digit_count,
  output logic       reject,
  output logic       timeout
);

  localparam logic [2:0] FULL_COUNT = 3'(PIN_LEN);

  pinState_e  state_q, state_d;
  logic [3:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic [2:0] count_q, count_d;
  pinPac_t    pin_q, pin_d;
  logic       reject_q, reject_d;
  logic       timeout_q, timeout_d;

  logic isDigitKey, isBksp, isEnter, keyAccepted, expire;

  assign isDigitKey  = isDigit(key_code);
  assign isBksp      = (key_code == KEY_BKSP);
  assign isEnter     = (key_code == KEY_ENTER);
  assign keyAccepted = enable && key_valid && (isDigitKey || isBksp || isEnter);

  pin_inactivity_timer #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (keyAccepted || !enable),
    .run   (state_q == ENTRY),
    .expire(expire)
  );

  // Priority: enable gate, then an accepted key, then timer expiry.
  // A key on the expiry cycle wins because the timer sees it as a clear.
  always_comb begin
    state_d   = (state_q == SUBMIT) ? IDLE : state_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    d3_d      = d3_q;
    d4_d      = d4_q;
    count_d   = count_q;
    pin_d     = pin_q;
    pin_d.status = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;

    if (!enable) begin
      {d1_d, d2_d, d3_d, d4_d} = {4{EMPTY_DIGIT}};
      count_d = '0;
      state_d = IDLE;
    end else if (keyAccepted) begin
      if (isDigitKey) begin
        {d1_d, d2_d, d3_d, d4_d} = {d2_q, d3_q, d4_q, key_code};
        count_d = (count_q >= FULL_COUNT) ? FULL_COUNT : count_q + 3'd1;
        state_d = ENTRY;
      end else if (isBksp) begin
        if (count_q != '0) begin
          {d1_d, d2_d, d3_d, d4_d} = {EMPTY_DIGIT, d1_q, d2_q, d3_q};
          count_d = count_q - 3'd1;
          state_d = (count_q == 3'd1) ? IDLE : ENTRY;
        end
      end else begin
        if (count_q == FULL_COUNT) begin
          pin_d   = '{status: 1'b1, d1: d1_q, d2: d2_q, d3: d3_q, d4: d4_q};
          state_d = SUBMIT;
        end else begin
          reject_d = 1'b1;
          state_d  = IDLE;
        end
        {d1_d, d2_d, d3_d, d4_d} = {4{EMPTY_DIGIT}};
        count_d = '0;
      end
    end else if (expire) begin
      {d1_d, d2_d, d3_d, d4_d} = {4{EMPTY_DIGIT}};
      count_d   = '0;
      timeout_d = 1'b1;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      d1_q      <= EMPTY_DIGIT;
      d2_q      <= EMPTY_DIGIT;
      d3_q      <= EMPTY_DIGIT;
      d4_q      <= EMPTY_DIGIT;
      count_q   <= '0;
      pin_q     <= '{status: 1'b0, d1: PIN_RESET_DIGIT, d2: PIN_RESET_DIGIT,
                     d3: PIN_RESET_DIGIT, d4: PIN_RESET_DIGIT};
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      d4_q      <= d4_d;
      count_q   <= count_d;
      pin_q     <= pin_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  assign pin_out     = pin_q;
  assign disp_d1     = d1_q;
  assign disp_d2     = d2_q;
  assign disp_d3     = d3_q;
  assign disp_d4     = d4_q;
  assign digit_count = count_q;
  assign reject      = reject_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pin_entry_assembler.sv
// Self-checking bench: directed walkthrough followed by random key traffic,
// compared every cycle against a queue-based model of the entry rules.
module tb_pin_entry_assembler;
  import pin_pkg::*;

  localparam int T = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  pinPac_t    pin_out;
  logic [3:0] disp_d1, disp_d2, disp_d3, disp_d4;
  logic [2:0] digit_count;
  logic       reject, timeout;

  int testsRun = 0;
  int failures = 0;

  // Reference model state: buffered digits oldest-first, idle cycle counter.
  int         digits[$];
  int         idle;
  logic       expStatus, expReject, expTimeout;
  logic [3:0] expPin[4];

  pin_entry_assembler #(.TIMEOUT_TICKS(T), .PIN_LEN(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .key_valid(key_valid),
    .key_code(key_code), .pin_out(pin_out), .disp_d1(disp_d1), .disp_d2(disp_d2),
    .disp_d3(disp_d3), .disp_d4(disp_d4), .digit_count(digit_count),
    .reject(reject), .timeout(timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  function automatic void modelReset();
    digits.delete();
    idle = 0;
    expStatus = 1'b0;
    expReject = 1'b0;
    expTimeout = 1'b0;
    for (int i = 0; i < 4; i++) expPin[i] = 4'hF;
  endfunction

  function automatic void modelStep(input logic en, input logic kv, input logic [3:0] kc);
    expStatus = 1'b0;
    expReject = 1'b0;
    expTimeout = 1'b0;
    if (!en) begin
      digits.delete();
      idle = 0;
    end else if (kv && (kc <= 4'd9 || kc == 4'hA || kc == 4'hC)) begin
      idle = 0;
      if (kc <= 4'd9) begin
        digits.push_back(int'(kc));
        if (digits.size() > 4) void'(digits.pop_front());
      end else if (kc == 4'hA) begin
        if (digits.size() > 0) void'(digits.pop_back());
      end else begin
        if (digits.size() == 4) begin
          for (int i = 0; i < 4; i++) expPin[i] = 4'(digits[i]);
          expStatus = 1'b1;
        end else begin
          expReject = 1'b1;
        end
        digits.delete();
      end
    end else if (digits.size() > 0) begin
      if (idle == T - 1) begin
        expTimeout = 1'b1;
        digits.delete();
        idle = 0;
      end else begin
        idle++;
      end
    end else begin
      idle = 0;
    end
  endfunction

  function automatic logic [15:0] expDisp();
    logic [15:0] v;
    int pad;
    pad = 4 - digits.size();
    for (int i = 0; i < 4; i++)
      v[15-4*i -: 4] = (i < pad) ? 4'hB : 4'(digits[i - pad]);
    return v;
  endfunction

  task automatic compareAll();
    checkOutput("pin_out", 32'(pin_out), 32'({expStatus, expPin[0], expPin[1], expPin[2], expPin[3]}));
    checkOutput("disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'(expDisp()));
    checkOutput("digit_count", 32'(digit_count), 32'(digits.size()));
    checkOutput("reject", 32'(reject), 32'(expReject));
    checkOutput("timeout", 32'(timeout), 32'(expTimeout));
  endtask

  task automatic applyStimulus(input logic en, input logic kv, input logic [3:0] kc);
    @(negedge clock);
    enable = en;
    key_valid = kv;
    key_code = kc;
    @(posedge clock);
    modelStep(en, kv, kc);
    #1;
    compareAll();
  endtask

  task automatic pressKeys(input logic [3:0] keys[$]);
    foreach (keys[i]) applyStimulus(1'b1, 1'b1, keys[i]);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'h0);
  endtask

  function automatic logic [3:0] randomCode();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 4'($urandom_range(0, 9));
    if (r < 80) return KEY_BKSP;
    if (r < 92) return KEY_ENTER;
    return 4'($urandom_range(10, 15));
  endfunction

  initial begin
    modelReset();
    #23;
    checkOutput("reset_pin", 32'(pin_out), 32'h0FFFF);
    checkOutput("reset_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'hBBBB);
    checkOutput("reset_count", 32'(digit_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idleCycles(10);
    checkOutput("idle_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'hBBBB);

    pressKeys('{4'd1, 4'd2, 4'd3, 4'd4});
    checkOutput("entry_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'h1234);
    pressKeys('{KEY_ENTER});
    checkOutput("submit_pin", 32'(pin_out), 32'h11234);
    checkOutput("submit_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'hBBBB);
    idleCycles(1);
    checkOutput("submit_hold", 32'(pin_out), 32'h01234);

    pressKeys('{4'd9, 4'd8, 4'd7, 4'd6, 4'd5});
    checkOutput("roll_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'h8765);
    checkOutput("roll_count", 32'(digit_count), 32'd4);
    pressKeys('{KEY_BKSP});
    checkOutput("bksp_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'hB876);
    pressKeys('{KEY_ENTER});
    checkOutput("short_reject", 32'(reject), 32'd1);
    checkOutput("short_pin", 32'(pin_out), 32'h01234);

    pressKeys('{4'd3, 4'd1});
    idleCycles(T - 1);
    checkOutput("pre_timeout", 32'(timeout), 32'd0);
    idleCycles(1);
    checkOutput("timeout_pulse", 32'(timeout), 32'd1);
    checkOutput("timeout_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'hBBBB);
    pressKeys('{4'd3, 4'd1});
    idleCycles(T - 1);
    pressKeys('{4'd7});
    checkOutput("late_key_timeout", 32'(timeout), 32'd0);
    checkOutput("late_key_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'hB317);
    pressKeys('{KEY_BKSP, KEY_BKSP, KEY_BKSP, KEY_BKSP});

    applyStimulus(1'b0, 1'b1, 4'd5);
    applyStimulus(1'b0, 1'b1, 4'd5);
    checkOutput("gated_count", 32'(digit_count), 32'd0);
    pressKeys('{4'd2, 4'd6});
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("drop_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'hBBBB);
    checkOutput("drop_reject", 32'(reject), 32'd0);

    pressKeys('{4'd4, 4'd5, 4'd6});
    key_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("midreset_pin", 32'(pin_out), 32'h0FFFF);
    checkOutput("midreset_disp", 32'({disp_d1, disp_d2, disp_d3, disp_d4}), 32'hBBBB);
    @(negedge clock);
    reset = 1'b0;
    pressKeys('{4'd7, 4'd8, 4'd9, 4'd0, KEY_ENTER});
    checkOutput("post_reset_pin", 32'(pin_out), 32'h17890);

    for (int c = 0; c < 4000; c++) begin
      if ((c % 500) < 20)
        applyStimulus(1'b1, 1'b0, randomCode());
      else
        applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, randomCode());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
